// File: rtl/aes_block_loader.sv
// -----------------------------------------------------------------------------
// aes_block_loader
//
// Sits downstream of the byte-to-word input port. It assembles the port's
// 32-bit words into a 128-bit key block and a 128-bit data block for the
// AES-128 core. Words arrive MSB-first within a block. When both blocks are
// complete it pulses start, then holds both blocks stable until core_done.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   in_word     32-bit word from the input port
//   in_valid    one-cycle pulse qualifying in_word
//   key_reload  one-cycle pulse: discard the key and reload it from the next
//               four words
//   core_done   one-cycle pulse from the AES core: operation finished
//   key_out     assembled 128-bit key
//   data_out    assembled 128-bit data block
//   key_valid   key_out holds a complete key
//   start       one-cycle pulse: key_out/data_out are ready for the core
//   busy        operation in flight (start issued, core_done not yet seen)
//   overrun     sticky: a word was dropped because busy was high
//
// Parameter
//   KEY_PERSIST 1: the key is loaded once and reused for every following
//               data block. 0: every operation takes a fresh key (8 words).
// -----------------------------------------------------------------------------
module aes_block_loader #(
   parameter int unsigned KEY_PERSIST = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  in_word,
   input  logic         in_valid,
   input  logic         key_reload,
   input  logic         core_done,
   output logic [127:0] key_out,
   output logic [127:0] data_out,
   output logic         key_valid,
   output logic         start,
   output logic         busy,
   output logic         overrun
);

   typedef enum logic [1:0] {
      S_KEY   = 2'd0,
      S_DATA  = 2'd1,
      S_START = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [127:0] key_q, key_d;
   logic [127:0] data_q, data_d;
   logic         key_valid_q, key_valid_d;
   logic         start_q, start_d;
   logic         busy_q, busy_d;
   logic         overrun_q, overrun_d;
   logic         reload_pending_q, reload_pending_d;

   // Word idx lands in bits [127-32*idx : 96-32*idx]; other bits are kept.
   function automatic logic [127:0] insert_word(input logic [127:0] blk,
                                                input logic [1:0]   idx,
                                                input logic [31:0]  w);
      logic [127:0] r;
      r = blk;
      case (idx)
         2'd0:    r[127:96] = w;
         2'd1:    r[95:64]  = w;
         2'd2:    r[63:32]  = w;
         default: r[31:0]   = w;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_KEY;
         cnt_q            <= 2'd0;
         key_q            <= '0;
         data_q           <= '0;
         key_valid_q      <= 1'b0;
         start_q          <= 1'b0;
         busy_q           <= 1'b0;
         overrun_q        <= 1'b0;
         reload_pending_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         key_q            <= key_d;
         data_q           <= data_d;
         key_valid_q      <= key_valid_d;
         start_q          <= start_d;
         busy_q           <= busy_d;
         overrun_q        <= overrun_d;
         reload_pending_q <= reload_pending_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      key_d            = key_q;
      data_d           = data_q;
      key_valid_d      = key_valid_q;
      start_d          = 1'b0;
      busy_d           = busy_q;
      overrun_d        = overrun_q;
      reload_pending_d = reload_pending_q;

      case (state_q)
         S_KEY: begin
            // key_reload beats a coincident word; the word is silently lost.
            if (key_reload) begin
               cnt_d       = 2'd0;
               key_valid_d = 1'b0;
            end else if (in_valid) begin
               key_d = insert_word(key_q, cnt_q, in_word);
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  key_valid_d = 1'b1;
                  state_d     = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (key_reload) begin
               cnt_d       = 2'd0;
               key_valid_d = 1'b0;
               state_d     = S_KEY;
            end else if (in_valid) begin
               data_d = insert_word(data_q, cnt_q, in_word);
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  start_d = 1'b1;
                  busy_d  = 1'b1;
                  state_d = S_START;
               end
            end
         end

         S_START: begin
            // core_done is not honoured here; the core has only just started.
            if (in_valid)   overrun_d        = 1'b1;
            if (key_reload) reload_pending_d = 1'b1;
            state_d = S_WAIT;
         end

         default: begin // S_WAIT
            if (in_valid)   overrun_d        = 1'b1;
            if (key_reload) reload_pending_d = 1'b1;
            if (core_done) begin
               busy_d = 1'b0;
               // A reload pulsed on the same edge as core_done still counts.
               if ((KEY_PERSIST != 0) && !(reload_pending_q || key_reload)) begin
                  state_d = S_DATA;
               end else begin
                  state_d          = S_KEY;
                  key_valid_d      = 1'b0;
                  reload_pending_d = 1'b0;
               end
            end
         end
      endcase
   end

   assign key_out   = key_q;
   assign data_out  = data_q;
   assign key_valid = key_valid_q;
   assign start     = start_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// -----------------------------------------------------------------------------
// Bench for aes_block_loader. Two instances run from the same stimulus:
// u_dut0 with KEY_PERSIST=1, u_dut1 with KEY_PERSIST=0. A word-level model of
// each is compared against every output on every falling edge after reset,
// and a few literal expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_aes_block_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in_word = '0;
   logic        in_valid = 1'b0;
   logic        key_reload = 1'b0;
   logic        core_done = 1'b0;

   logic [127:0] key0, data0, key1, data1;
   logic         kv0, st0, bz0, ov0, kv1, st1, bz1, ov1;

   always #5 clk = ~clk;

   aes_block_loader #(.KEY_PERSIST(1)) u_dut0 (
      .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
      .key_reload(key_reload), .core_done(core_done),
      .key_out(key0), .data_out(data0), .key_valid(kv0),
      .start(st0), .busy(bz0), .overrun(ov0));

   aes_block_loader #(.KEY_PERSIST(0)) u_dut1 (
      .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
      .key_reload(key_reload), .core_done(core_done),
      .key_out(key1), .data_out(data1), .key_valid(kv1),
      .start(st1), .busy(bz1), .overrun(ov1));

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Per instance: collected words so far in the current block (widx), whether
   // the block being collected is the key, and the visible outputs.
   logic [127:0] m_key [2];
   logic [127:0] m_data[2];
   bit m_kv[2], m_start[2], m_busy[2], m_ovr[2], m_pend[2], m_loading_key[2];
   int m_widx[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_key[i] = '0; m_data[i] = '0;
            m_kv[i] = 0; m_start[i] = 0; m_busy[i] = 0; m_ovr[i] = 0;
            m_pend[i] = 0; m_loading_key[i] = 1; m_widx[i] = 0;
         end else if (m_busy[i]) begin
            if (in_valid)   m_ovr[i]  = 1;
            if (key_reload) m_pend[i] = 1;
            // The start cycle itself does not accept core_done.
            if (core_done && !m_start[i]) begin
               m_busy[i] = 0;
               if (i == 0 && !m_pend[i]) begin
                  m_loading_key[i] = 0;
               end else begin
                  m_loading_key[i] = 1;
                  m_kv[i] = 0;
                  m_pend[i] = 0;
               end
            end
            m_start[i] = 0;
         end else if (key_reload) begin
            m_widx[i] = 0; m_kv[i] = 0; m_loading_key[i] = 1;
         end else if (in_valid) begin
            if (m_loading_key[i]) m_key[i][127 - 32*m_widx[i] -: 32] = in_word;
            else                  m_data[i][127 - 32*m_widx[i] -: 32] = in_word;
            m_widx[i]++;
            if (m_widx[i] == 4) begin
               m_widx[i] = 0;
               if (m_loading_key[i]) begin
                  m_kv[i] = 1; m_loading_key[i] = 0;
               end else begin
                  m_start[i] = 1; m_busy[i] = 1;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("key0", key0, m_key[0]);   chk("data0", data0, m_data[0]);
         chk("kv0", 128'(kv0), 128'(m_kv[0]));   chk("start0", 128'(st0), 128'(m_start[0]));
         chk("busy0", 128'(bz0), 128'(m_busy[0])); chk("ovr0", 128'(ov0), 128'(m_ovr[0]));
         chk("key1", key1, m_key[1]);   chk("data1", data1, m_data[1]);
         chk("kv1", 128'(kv1), 128'(m_kv[1]));   chk("start1", 128'(st1), 128'(m_start[1]));
         chk("busy1", 128'(bz1), 128'(m_busy[1])); chk("ovr1", 128'(ov1), 128'(m_ovr[1]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_word(input logic [31:0] w);
      in_word = w; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_done();
      core_done = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0;
   endtask

   task automatic pulse_reload();
      key_reload = 1'b1;
      @(posedge clk); #1;
      key_reload = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send4(input logic [31:0] base);
      for (int k = 0; k < 4; k++) send_word(base + 32'(k));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("reset_key0", key0, 128'h0);
      chk("reset_flags0", {124'h0, kv0, st0, bz0, ov0}, 128'h0);

      // key_reload with a coincident word: word dropped, no overrun
      key_reload = 1'b1; in_word = 32'hFFFF_FFFF; in_valid = 1'b1;
      @(posedge clk); #1;
      key_reload = 1'b0; in_valid = 1'b0;
      chk("reload_drop_key0", key0, 128'h0);
      chk("reload_drop_ovr0", 128'(ov0), 128'h0);

      // key + data load
      send_word(32'h0001_0203); send_word(32'h0405_0607);
      send_word(32'h0809_0A0B);
      chk("kv_before_4th", 128'(kv0), 128'h0);
      send_word(32'h0C0D_0E0F);
      chk("kv_after_4th", 128'(kv0), 128'h1);
      chk("key_literal", key0, 128'h000102030405060708090A0B0C0D0E0F);
      send_word(32'h0011_2233); send_word(32'h4455_6677);
      send_word(32'h8899_AABB);
      chk("no_start_early", 128'(st0), 128'h0);
      send_word(32'hCCDD_EEFF);
      chk("data_literal", data0, 128'h00112233445566778899AABBCCDDEEFF);
      chk("start_after_8th", 128'(st0), 128'h1);
      chk("busy_after_8th", 128'(bz0), 128'h1);
      idle(1);
      chk("start_one_cycle", 128'(st0), 128'h0);
      chk("busy_held", 128'(bz0), 128'h1);

      // overrun during wait
      send_word(32'hDEAD_BEEF);
      chk("overrun_set", 128'(ov0), 128'h1);
      chk("overrun_data_kept", data0, 128'h00112233445566778899AABBCCDDEEFF);
      pulse_done();
      chk("busy_drop", 128'(bz0), 128'h0);
      chk("overrun_sticky", 128'(ov0), 128'h1);
      chk("kv_persist", 128'(kv0), 128'h1);
      chk("kv_nopersist", 128'(kv1), 128'h0);

      // key reuse on dut0; dut1 takes these as a new key
      send4(32'hA000_0000);
      chk("reuse_key_kept", key0, 128'h000102030405060708090A0B0C0D0E0F);
      chk("reuse_start", 128'(st0), 128'h1);
      chk("np_key_new", key1, 128'hA0000000A0000001A0000002A0000003);
      chk("np_no_start", 128'(st1), 128'h0);
      idle(2);
      pulse_done();
      send4(32'hB000_0000);           // dut0: data; dut1: data -> start
      chk("np_start_after_8", 128'(st1), 128'h1);
      idle(1);
      core_done = 1'b1; in_word = 32'h1234_5678; in_valid = 1'b1; // word on done edge dropped
      @(posedge clk); #1;
      core_done = 1'b0; in_valid = 1'b0;
      idle(1);

      // mid-block reload
      send_word(32'hC000_0000); send_word(32'hC000_0001);
      pulse_reload();
      chk("midreload_kv", 128'(kv0), 128'h0);
      send4(32'hD000_0000);
      chk("midreload_key", key0, 128'hD0000000D0000001D0000002D0000003);
      send4(32'hE000_0000);
      idle(1);
      // reload during wait only acts at core_done
      pulse_reload();
      chk("pending_kv_held", 128'(kv0), 128'h1);
      pulse_done();
      chk("pending_kv_clear", 128'(kv0), 128'h0);

      // reset in S_WAIT with coincident core_done
      send4(32'hF000_0000); send4(32'hF100_0000);
      idle(1);
      rst = 1'b1; core_done = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; core_done = 1'b0;
      chk("rst_key", key0, 128'h0);
      chk("rst_flags", {124'h0, kv0, st0, bz0, ov0}, 128'h0);
      send_word(32'h5A5A_A5A5);
      chk("post_rst_word", key0, 128'h5A5AA5A5000000000000000000000000);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
